// File: rtl/axi_sched_pkg.sv
// Shared types and round-robin pick helper for the AXI write scheduler.
package axi_sched_pkg;

    localparam int unsigned MAX_M  = 4;
    localparam int unsigned PICK_W = 2;

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} wsched_state_e;

    // First requester after ptr, scanning upward with wrap over n masters; ptr if none.
    function automatic logic [PICK_W-1:0] rr_pick(input logic [MAX_M-1:0]  req,
                                                  input logic [PICK_W-1:0] ptr,
                                                  input logic [2:0]        n);
        logic [PICK_W-1:0] pick;
        logic [2:0]        idx;
        pick = ptr;
        // Walk from farthest to nearest so the nearest requester overwrites last.
        for (int k = MAX_M; k >= 1; k--) begin
            idx = 3'(ptr) + 3'(k);
            if (idx >= n) idx = idx - n;
            if ((3'(k) <= n) && req[idx[1:0]]) pick = idx[1:0];
        end
        return pick;
    endfunction

endpackage

// File: rtl/axi_write_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: request vector and last-owner pointer in, grant out.
module rr_arbiter
    import axi_sched_pkg::*;
#(
    parameter int unsigned NUM_M    = 2,
    parameter int unsigned IDX_BITS = 2
) (
    input  logic [NUM_M-1:0]    req,
    input  logic [IDX_BITS-1:0] ptr,
    output logic [NUM_M-1:0]    gnt_oh_c,
    output logic [IDX_BITS-1:0] gnt_idx_c,
    output logic                any_c
);

    always_comb begin
        gnt_oh_c  = '0;
        any_c     = |req;
        gnt_idx_c = IDX_BITS'(rr_pick(MAX_M'(req), PICK_W'(ptr), 3'(NUM_M)));
        for (int i = 0; i < NUM_M; i++) begin
            gnt_oh_c[i] = any_c && (gnt_idx_c == IDX_BITS'(i));
        end
    end

endmodule

// File: rtl/axi_write_scheduler.sv
// Shares one downstream AXI write path between NUM_M masters; one write in flight,
// round-robin on AW, grant held through the W burst and the B response.
module axi_write_scheduler
    import axi_sched_pkg::*;
#(
    parameter int unsigned NUM_M    = 2,
    parameter int unsigned LEN_BITS = 4,
    parameter int unsigned IDX_BITS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_M-1:0]          awvalid_m,
    input  logic [NUM_M*LEN_BITS-1:0] awlen_m,
    output logic [NUM_M-1:0]          awready_m,
    input  logic [NUM_M-1:0]          wvalid_m,
    input  logic [NUM_M-1:0]          wlast_m,
    output logic [NUM_M-1:0]          wready_m,
    output logic [NUM_M-1:0]          bvalid_m,
    input  logic [NUM_M-1:0]          bready_m,
    output logic                      aw_valid_s,
    input  logic                      aw_ready_s,
    output logic                      w_valid_s,
    output logic                      w_last_s,
    input  logic                      w_ready_s,
    input  logic                      b_valid_s,
    output logic                      b_ready_s,
    output logic [IDX_BITS-1:0]       grant_idx,
    output logic                      busy,
    output logic                      wlast_err
);

    wsched_state_e       state_q, state_d;
    logic [IDX_BITS-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_BITS-1:0] grant_idx_q, grant_idx_d;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic [LEN_BITS-1:0] beat_cnt_q, beat_cnt_d;
    logic                wlast_err_q, wlast_err_d;

    logic [NUM_M-1:0]    arb_oh;
    logic [IDX_BITS-1:0] arb_idx;
    logic                arb_any;
    logic [LEN_BITS-1:0] arb_len;
    logic [NUM_M-1:0]    own;
    logic                awvalid_g, wvalid_g, wlast_g, bready_g, final_beat;

    rr_arbiter #(
        .NUM_M    (NUM_M),
        .IDX_BITS (IDX_BITS)
    ) u_arb (
        .req       (awvalid_m),
        .ptr       (rr_ptr_q),
        .gnt_oh_c  (arb_oh),
        .gnt_idx_c (arb_idx),
        .any_c     (arb_any)
    );

    // Owner mask and owner-selected inputs; AWLEN of the arbitration winner.
    always_comb begin
        own     = '0;
        arb_len = '0;
        for (int i = 0; i < NUM_M; i++) begin
            own[i] = (grant_idx_q == IDX_BITS'(i));
            if (arb_oh[i]) arb_len = arb_len | awlen_m[i*LEN_BITS +: LEN_BITS];
        end
        awvalid_g  = |(awvalid_m & own);
        wvalid_g   = |(wvalid_m & own);
        wlast_g    = |(wlast_m & own);
        bready_g   = |(bready_m & own);
        final_beat = (beat_cnt_q == len_q);
    end

    // Next state and per-phase channel gating.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        len_d       = len_q;
        beat_cnt_d  = beat_cnt_q;
        wlast_err_d = 1'b0;
        aw_valid_s  = 1'b0;
        w_valid_s   = 1'b0;
        w_last_s    = 1'b0;
        b_ready_s   = 1'b0;
        awready_m   = '0;
        wready_m    = '0;
        bvalid_m    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    grant_idx_d = arb_idx;
                    len_d       = arb_len;
                    state_d     = S_AW;
                end
            end
            S_AW: begin
                aw_valid_s = awvalid_g;
                awready_m  = own & {NUM_M{aw_ready_s}};
                if (awvalid_g && aw_ready_s) begin
                    beat_cnt_d = '0;
                    state_d    = S_W;
                end
            end
            S_W: begin
                w_valid_s = wvalid_g;
                wready_m  = own & {NUM_M{w_ready_s}};
                w_last_s  = final_beat;
                if (wvalid_g && w_ready_s) begin
                    beat_cnt_d  = beat_cnt_q + LEN_BITS'(1);
                    // Burst length always comes from len_q; WLAST is only cross-checked.
                    wlast_err_d = (wlast_g != final_beat);
                    if (final_beat) state_d = S_B;
                end
            end
            S_B: begin
                bvalid_m  = own & {NUM_M{b_valid_s}};
                b_ready_s = bready_g;
                if (b_valid_s && bready_g) begin
                    rr_ptr_d = grant_idx_q;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= IDX_BITS'(NUM_M - 1);
            grant_idx_q <= '0;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            wlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            wlast_err_q <= wlast_err_d;
        end
    end

    assign grant_idx = grant_idx_q;
    assign busy      = (state_q != S_IDLE);
    assign wlast_err = wlast_err_q;

endmodule
